fp_rshift_seq: RTL and testbench

//  Sequential, parametrised IEEE-754 scale-down unit: result = a / 2^shamt, with truncation.

---
 rtl/fp_rshift_seq.sv | 129 ++++++++++++
 tb/tb_fp_rshift_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fp_rshift_seq.sv
// Sequential IEEE-754 scale-down unit: result = a / 2^shamt, truncating.
// One halving per cycle; start/busy/done handshake with fixed latency.
module fp_rshift_seq #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 23,
    parameter int unsigned SHAMT_W = 5,
    parameter logic [3:0]  OPCODE  = 4'd8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               operation,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [SHAMT_W-1:0]       shamt,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     underflow
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               uf_q, uf_d;
    logic               accept_c;
    logic [EXP_W-1:0]   exp_c, exp_n;
    logic [MAN_W-1:0]   man_c, man_n;
    logic               lost_c;

    assign exp_c = work_q[W-2 -: EXP_W];
    assign man_c = work_q[MAN_W-1:0];

    // Single halving step; inf/NaN untouched, hidden bit enters on normal->subnormal.
    always_comb begin
        exp_n  = exp_c;
        man_n  = man_c;
        lost_c = 1'b0;
        if (exp_c == {EXP_W{1'b1}}) begin
            exp_n = exp_c;
        end else if (exp_c > EXP_W'(1)) begin
            exp_n = exp_c - EXP_W'(1);
        end else if (exp_c == EXP_W'(1)) begin
            exp_n  = '0;
            man_n  = {1'b1, man_c[MAN_W-1:1]};
            lost_c = man_c[0];
        end else begin
            man_n  = man_c >> 1;
            lost_c = man_c[0];
        end
    end

    // Next-state logic; the SHIFT phase spends one extra cycle draining cnt==0
    // so that DONE always lands shamt+1 edges after the accept.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        uf_d     = uf_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (operation == OPCODE)) begin
                    accept_c = 1'b1;
                    state_d  = SHIFT;
                    work_d   = a;
                    cnt_d    = shamt;
                    uf_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    work_d = {work_q[W-1], exp_n, man_n};
                    uf_d   = uf_q | lost_c;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            uf_q    <= uf_d;
        end
    end

    // Registered outputs track the next state so they align with the state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            underflow <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
            if (state_d == DONE) begin
                result    <= work_d;
                underflow <= uf_d;
            end else if (accept_c) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_rshift_seq.sv
// Directed bench for fp_rshift_seq: vector table plus handshake, abort and
// ignored-request sequences, all against hand-computed expectations.
module tb_fp_rshift_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  operation;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        underflow;

    int checks;
    int errors;

    fp_rshift_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .a(a), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        uf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept one operation; optionally pulse a stray start poke_at cycles after accept.
    task automatic run(input logic [31:0] av, input logic [4:0] sv,
                       input logic [31:0] er, input logic eu, input int poke_at);
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1; operation = 4'd8; a = av; shamt = sv;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEADBEEF; shamt = 5'd7;
        chk("busy_at_accept", 32'(busy), 32'd1);
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1; a = 32'h7F7FFFFF; shamt = 5'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(n), 32'(sv) + 32'd1);
        chk("result", result, er);
        chk("underflow", 32'(underflow), 32'(eu));
        chk("busy_in_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("busy_cleared", {31'd0, busy}, 32'd0);
        chk("result_held", result, er);
    endtask

    initial begin
        checks = 0; errors = 0;
        start = 1'b0; operation = 4'd0; a = '0; shamt = '0;
        vecs[0] = '{32'h40800000, 5'd2,  32'h3F800000, 1'b0};
        vecs[1] = '{32'h00800001, 5'd1,  32'h00400000, 1'b1};
        vecs[2] = '{32'h00800000, 5'd1,  32'h00400000, 1'b0};
        vecs[3] = '{32'h80000001, 5'd1,  32'h80000000, 1'b1};
        vecs[4] = '{32'h00000000, 5'd31, 32'h00000000, 1'b0};
        vecs[5] = '{32'h7F800000, 5'd5,  32'h7F800000, 1'b0};
        vecs[6] = '{32'h7FC00001, 5'd5,  32'h7FC00001, 1'b0};
        vecs[7] = '{32'h3F800000, 5'd0,  32'h3F800000, 1'b0};
        vecs[8] = '{32'h00800000, 5'd3,  32'h00100000, 1'b0};
        vecs[9] = '{32'h01C00003, 5'd4,  32'h00300000, 1'b1};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run(vecs[i].a, vecs[i].sh, vecs[i].res, vecs[i].uf, 0);

        // Wrong opcode never accepted; result keeps the last value.
        @(negedge clk);
        start = 1'b1; operation = 4'd3; a = 32'h40000000; shamt = 5'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("wrong_op_busy", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;
        chk("wrong_op_result", result, 32'h00300000);

        // Start pulsed while busy is ignored: 4.0 / 16 = 0.25.
        run(32'h40800000, 5'd4, 32'h3E800000, 1'b0, 2);

        // Start held through the DONE cycle is ignored.
        @(negedge clk);
        start = 1'b1; operation = 4'd8; a = 32'h40000000; shamt = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("dc_done", {31'd0, done}, 32'd1);
        start = 1'b1; a = 32'h12345678; shamt = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("dc_ignored_busy", {31'd0, busy}, 32'd0);
        chk("dc_result", result, 32'h40000000);

        // Reset mid-operation aborts immediately.
        @(negedge clk);
        start = 1'b1; operation = 4'd8; a = 32'h00800001; shamt = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_underflow", {31'd0, underflow}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        run(32'h40800000, 5'd2, 32'h3F800000, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
